// File: rtl/op_0110011_pkg.sv
// Shared constants and types for the RV32I R-type issue/writeback sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package op_0110011_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/op_0110011_if.sv
// Instruction handshake, ALU operand/result and completion signals of the issue block.
// Latency: n/a (wiring only).
// Backpressure: instr_ready gates instr_valid; master = issue block, slave = environment/ALU side.
interface op_0110011_if;
  import op_0110011_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [6:0]      alu_funct7;
  logic [2:0]      alu_funct3;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [XLEN-1:0] alu_result;
  logic            done_valid;
  reg_idx_t        done_rd;
  logic [XLEN-1:0] done_value;
  logic            illegal;

  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_funct7, alu_funct3, alu_rs1, alu_rs2,
           done_valid, done_rd, done_value, illegal
  );

  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_funct7, alu_funct3, alu_rs1, alu_rs2,
           done_valid, done_rd, done_value, illegal
  );

endinterface

// File: rtl/op_0110011_regfile.sv
// x1..x31 register file, two operand read ports, one debug read port, one write port; x0 reads 0.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none; the parent arbitrates the single write port.
module op_0110011_regfile
  import op_0110011_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  reg_idx_t        rd_addr_a,
  input  reg_idx_t        rd_addr_b,
  input  reg_idx_t        dbg_addr,
  input  logic            we,
  input  reg_idx_t        waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  function automatic logic [XLEN-1:0] rd_port(input reg_idx_t a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  assign rd_data_a = rd_port(rd_addr_a);
  assign rd_data_b = rd_port(rd_addr_b);
  assign dbg_data  = rd_port(dbg_addr);

  // Synchronous clear on reset, otherwise single write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/op_0110011_issue.sv
// Issue/writeback sequencer for RV32I R-type: accept, read operands, drive ALU, write back result.
// Latency: accept in cycle 0, ALU operands cycle 1, writeback edge end of cycle 2, done_valid cycle 3.
// Backpressure: instr_ready high only in IDLE (one instruction in flight); optional macro OP_0110011_FUNCT7_CHECK_EN.
module op_0110011_issue
  import op_0110011_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  op_0110011_if.master    bus,
  input  logic            load_en,
  input  reg_idx_t        load_addr,
  input  logic [XLEN-1:0] load_data,
  input  reg_idx_t        dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_WB   = WB;

  logic [1:0]      state;
  logic [6:0]      funct7_q;
  logic [2:0]      funct3_q;
  reg_idx_t        rd_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic            illegal_q;
  logic            done_valid_q;
  reg_idx_t        done_rd_q;
  logic [XLEN-1:0] done_value_q;

  logic [6:0]      dec_opcode;
  logic [6:0]      dec_funct7;
  logic [2:0]      dec_funct3;
  reg_idx_t        dec_rs1;
  reg_idx_t        dec_rs2;
  reg_idx_t        dec_rd;
  logic            accept;
  logic            legal;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wr_en;
  reg_idx_t        wr_addr;
  logic [XLEN-1:0] wr_data;

  assign dec_opcode = bus.instr[6:0];
  assign dec_rd     = bus.instr[11:7];
  assign dec_funct3 = bus.instr[14:12];
  assign dec_rs1    = bus.instr[19:15];
  assign dec_rs2    = bus.instr[24:20];
  assign dec_funct7 = bus.instr[31:25];

  assign bus.instr_ready = (state == ST_IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;

  // Legality: opcode always; funct7/funct3 pairing only when the strict check is built in.
  always_comb begin
    legal = (dec_opcode == OPCODE_OP);
`ifdef OP_0110011_FUNCT7_CHECK_EN
    legal = legal && ((dec_funct7 == FUNCT7_BASE) ||
                      ((dec_funct7 == FUNCT7_ALT) &&
                       ((dec_funct3 == 3'd0) || (dec_funct3 == 3'd5))));
`endif
  end

  // Write port mux: WB result has the port in WB, the preload only while IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == ST_WB) begin
      wr_en   = (rd_q != '0);
      wr_addr = rd_q;
      wr_data = bus.alu_result;
    end else if ((state == ST_IDLE) && load_en && (load_addr != '0)) begin
      wr_en   = 1'b1;
      wr_addr = load_addr;
      wr_data = load_data;
    end
  end

  op_0110011_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (dec_rs1),
    .rd_addr_b (dec_rs2),
    .dbg_addr  (dbg_addr),
    .we        (wr_en),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data),
    .dbg_data  (dbg_data)
  );

  // Sequencer: IDLE -> EXEC -> WB -> IDLE; rejected instructions never leave IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept && legal) state <= ST_EXEC;
        ST_EXEC: state <= ST_WB;
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decode latches; operands sampled at the accept edge, so a same-edge preload is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct7_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else if (accept && legal) begin
      funct7_q <= dec_funct7;
      funct3_q <= dec_funct3;
      rd_q     <= dec_rd;
      op1_q    <= rs1_data;
      op2_q    <= rs2_data;
    end
  end

  // One-cycle illegal and done pulses; done payload holds until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_rd_q    <= '0;
      done_value_q <= '0;
    end else begin
      illegal_q    <= accept && !legal;
      done_valid_q <= (state == ST_WB);
      if (state == ST_WB) begin
        done_rd_q    <= rd_q;
        done_value_q <= bus.alu_result;
      end
    end
  end

  assign bus.alu_funct7 = funct7_q;
  assign bus.alu_funct3 = funct3_q;
  assign bus.alu_rs1    = op1_q;
  assign bus.alu_rs2    = op2_q;
  assign bus.illegal    = illegal_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_rd    = done_rd_q;
  assign bus.done_value = done_value_q;

endmodule

// File: tb/tb_op_0110011_issue.sv
// Directed bench for op_0110011_issue with a registered reference ALU and a result scoreboard.
// Latency: expects operands in cycle 1 and done_valid in cycle 3 after accept.
// Backpressure: issues only while instr_ready is checked high.
module tb_op_0110011_issue;
  import op_0110011_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  reg_idx_t    load_addr = '0;
  logic [31:0] load_data = '0;
  reg_idx_t    dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] alu_q = '0;

  op_0110011_if bus ();

  op_0110011_issue dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] ref_alu(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic tb_legal(input logic [31:0] ins);
    logic ok;
    ok = (ins[6:0] == 7'b0110011);
`ifdef OP_0110011_FUNCT7_CHECK_EN
    ok = ok && ((ins[31:25] == 7'h00) ||
                ((ins[31:25] == 7'h20) && ((ins[14:12] == 3'd0) || (ins[14:12] == 3'd5))));
`endif
    return ok;
  endfunction

  // Reference ALU: registers whatever operands are presented, result valid next cycle.
  always @(posedge clk) alu_q <= ref_alu(bus.alu_funct7, bus.alu_funct3, bus.alu_rs1, bus.alu_rs2);
  assign bus.alu_result = alu_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Drives one instruction in the current cycle; pending load_* inputs share the accept edge.
  task automatic issue(input logic [31:0] ins, input string tag);
    logic [31:0] a, b, val;
    logic [4:0]  rd;
    logic        ok;
    exp_t        e;
    rd  = ins[11:7];
    a   = model[ins[19:15]];
    b   = model[ins[24:20]];
    ok  = tb_legal(ins);
    val = ref_alu(ins[31:25], ins[14:12], a, b);
    if (ok) begin
      sb.push_back('{rd, val});
      if (rd != 5'd0) model[rd] = val;
    end
    bus.instr = ins; bus.instr_valid = 1'b1;
    chk({tag, ".ready0"}, {31'b0, bus.instr_ready}, 32'd1);
    tick();
    bus.instr_valid = 1'b0; load_en = 1'b0;
    if (!ok) begin
      chk({tag, ".illegal"}, {31'b0, bus.illegal}, 32'd1);
      chk({tag, ".ready1"}, {31'b0, bus.instr_ready}, 32'd1);
      tick();
      chk({tag, ".illegal_drop"}, {31'b0, bus.illegal}, 32'd0);
      chk({tag, ".no_done"}, {31'b0, bus.done_valid}, 32'd0);
      tick();
      chk({tag, ".no_done2"}, {31'b0, bus.done_valid}, 32'd0);
    end else begin
      chk({tag, ".f7"}, {25'b0, bus.alu_funct7}, {25'b0, ins[31:25]});
      chk({tag, ".rs1"}, bus.alu_rs1, a);
      chk({tag, ".rs2"}, bus.alu_rs2, b);
      chk({tag, ".busy"}, {31'b0, bus.instr_ready}, 32'd0);
      tick();
      chk({tag, ".early_done"}, {31'b0, bus.done_valid}, 32'd0);
      tick();
      chk({tag, ".done"}, {31'b0, bus.done_valid}, 32'd1);
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, ".done_rd"}, {27'b0, bus.done_rd}, {27'b0, e.rd});
        chk({tag, ".done_value"}, bus.done_value, e.val);
      end
      chk({tag, ".ready3"}, {31'b0, bus.instr_ready}, 32'd1);
      dbg_chk({tag, ".dbg_rd"}, rd, model[rd]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst.ready", {31'b0, bus.instr_ready}, 32'd1);
    chk("rst.done_valid", {31'b0, bus.done_valid}, 32'd0);
    chk("rst.illegal", {31'b0, bus.illegal}, 32'd0);
    chk("rst.done_rd", {27'b0, bus.done_rd}, 32'd0);
    chk("rst.done_value", bus.done_value, 32'd0);
    chk("rst.alu_rs1", bus.alu_rs1, 32'd0);
    dbg_chk("rst.dbg_x5", 5'd5, 32'd0);

    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    load(5'd0, 32'hDEAD_BEEF);
    dbg_chk("load.x1", 5'd1, 32'd5);
    dbg_chk("load.x0", 5'd0, 32'd0);

    issue(32'h002081B3, "add_x3");
    issue(32'h40208233, "sub_x4");
    issue(32'h0011A333, "slt_x6");
    issue(32'h00208033, "add_x0");
    issue(32'h000002B3, "add_x5");
    issue(32'h00500093, "addi");
    dbg_chk("addi.x1", 5'd1, 32'd5);
    issue(32'h02208233, "f7_one");
    dbg_chk("f7_one.x4", 5'd4, model[4]);

    // Preload x1 on the accept edge of ADD x7,x1,x2: operand must be the old x1.
    load_en = 1'b1; load_addr = 5'd1; load_data = 32'd100;
    issue(32'h002083B3, "add_x7_ld");
    model[1] = 32'd100;
    dbg_chk("ld_same.x1", 5'd1, 32'd100);

    // Reset during EXEC aborts the instruction.
    bus.instr = 32'h002081B3; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort.no_done", {31'b0, bus.done_valid}, 32'd0);
      tick();
    end
    chk("abort.ready", {31'b0, bus.instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) dbg_chk("abort.dbg", 5'(i), 32'd0);

    chk("sb.drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
